// File: rtl/id_stage_hs.sv
// id_stage_hs: RV base-ISA decode stage with one ID/EX register and
// valid/ready handshakes on both sides. Register-file reads are bypassed from
// the write-back port.
// Optional: ID_LOAD_USE_STALL_EN enables the load-use hazard stall; without it
// the EX-side load inputs are ignored.
module id_stage_hs #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instruction,
    output logic [4:0]      o_rs1_index,
    output logic [4:0]      o_rs2_index,
    input  logic [XLEN-1:0] i_rs1_value,
    input  logic [XLEN-1:0] i_rs2_value,
    input  logic            i_wb_write,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_value,
    input  logic            i_ex_mem_read,
    input  logic [4:0]      i_ex_rd,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_idex_instruction,
    output logic [XLEN-1:0] o_idex_pc,
    output logic [XLEN-1:0] o_idex_rs1_value,
    output logic [XLEN-1:0] o_idex_rs2_value,
    output logic [XLEN-1:0] o_idex_immediate,
    output logic [4:0]      o_idex_rd,
    output logic [1:0]      o_idex_alu_op,
    output logic            o_idex_alu_src,
    output logic            o_idex_op_a_pc,
    output logic            o_idex_branch,
    output logic            o_idex_jump,
    output logic            o_idex_mem_write,
    output logic            o_idex_mem_read,
    output logic            o_idex_mem_to_reg,
    output logic            o_idex_reg_write,
    output logic            o_idex_illegal
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0]     instruction;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic [XLEN-1:0] immediate;
        logic [4:0]      rd;
        logic [1:0]      alu_op;
        logic            alu_src;
        logic            op_a_pc;
        logic            branch;
        logic            jump;
        logic            mem_write;
        logic            mem_read;
        logic            mem_to_reg;
        logic            reg_write;
        logic            illegal;
    } idex_t;

    idex_t      idex_d, idex_q;
    logic       valid_q;
    logic       use_rs1, use_rs2;
    logic       hazard, accept;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2;

    assign opcode      = i_instruction[6:0];
    assign rs1         = i_instruction[19:15];
    assign rs2         = i_instruction[24:20];
    assign o_rs1_index = rs1;
    assign o_rs2_index = rs2;

    // x0 reads zero; a same-cycle write-back to the source wins over the RF
    function automatic logic [XLEN-1:0] src_read(input logic [4:0] idx,
                                                 input logic [XLEN-1:0] rf);
        if (idx == 5'd0)                    return '0;
        else if (i_wb_write && i_wb_rd == idx) return i_wb_value;
        else                                return rf;
    endfunction

    // Decode: controls, immediate select, operand capture, source usage
    always_comb begin
        idex_d             = '0;
        use_rs1            = 1'b0;
        use_rs2            = 1'b0;
        idex_d.instruction = i_instruction;
        idex_d.pc          = i_pc;
        idex_d.rd          = i_instruction[11:7];   // raw field, gated by reg_write downstream
        idex_d.rs1_value   = src_read(rs1, i_rs1_value);
        idex_d.rs2_value   = src_read(rs2, i_rs2_value);
        case (opcode)
            OP_LOAD: begin
                idex_d.immediate  = XLEN'($signed(i_instruction[31:20]));
                idex_d.alu_src    = 1'b1;
                idex_d.mem_read   = 1'b1;
                idex_d.mem_to_reg = 1'b1;
                idex_d.reg_write  = 1'b1;
                use_rs1           = 1'b1;
            end
            OP_STORE: begin
                idex_d.immediate = XLEN'($signed({i_instruction[31:25], i_instruction[11:7]}));
                idex_d.alu_src   = 1'b1;
                idex_d.mem_write = 1'b1;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OP_BRANCH: begin
                idex_d.immediate = XLEN'($signed({i_instruction[31], i_instruction[7],
                                                  i_instruction[30:25], i_instruction[11:8], 1'b0}));
                idex_d.alu_op    = 2'b01;
                idex_d.branch    = 1'b1;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OP_IMM: begin
                idex_d.immediate = XLEN'($signed(i_instruction[31:20]));
                idex_d.alu_op    = 2'b11;
                idex_d.alu_src   = 1'b1;
                idex_d.reg_write = 1'b1;
                use_rs1          = 1'b1;
            end
            OP_R: begin
                idex_d.alu_op    = 2'b10;
                idex_d.reg_write = 1'b1;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OP_LUI: begin
                idex_d.immediate = XLEN'($signed({i_instruction[31:12], 12'b0}));
                idex_d.alu_src   = 1'b1;
                idex_d.reg_write = 1'b1;
                idex_d.rs1_value = '0;      // LUI computes 0 + imm
            end
            OP_AUIPC: begin
                idex_d.immediate = XLEN'($signed({i_instruction[31:12], 12'b0}));
                idex_d.op_a_pc   = 1'b1;
                idex_d.alu_src   = 1'b1;
                idex_d.reg_write = 1'b1;
            end
            OP_JAL: begin
                idex_d.immediate = XLEN'($signed({i_instruction[31], i_instruction[19:12],
                                                  i_instruction[20], i_instruction[30:21], 1'b0}));
                idex_d.jump      = 1'b1;
                idex_d.op_a_pc   = 1'b1;
                idex_d.reg_write = 1'b1;
            end
            OP_JALR: begin
                idex_d.immediate = XLEN'($signed(i_instruction[31:20]));
                idex_d.jump      = 1'b1;
                idex_d.alu_src   = 1'b1;
                idex_d.reg_write = 1'b1;
                use_rs1          = 1'b1;
            end
            default: idex_d.illegal = 1'b1;
        endcase
    end

`ifdef ID_LOAD_USE_STALL_EN
    // Stall when a load in EX produces a source this instruction reads
    assign hazard = i_valid && i_ex_mem_read && (i_ex_rd != 5'd0) &&
                    ((use_rs1 && i_ex_rd == rs1) || (use_rs2 && i_ex_rd == rs2));
`else
    logic unused_ex;
    assign hazard    = 1'b0;
    assign unused_ex = ^{i_ex_mem_read, i_ex_rd, use_rs1, use_rs2};
`endif

    assign o_ready = (!valid_q || i_ready) && !hazard && !i_flush;
    assign accept  = i_valid && o_ready;

    // ID/EX register: flush beats accept, accept beats drain, otherwise hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            idex_q  <= '0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            idex_q  <= idex_d;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid            = valid_q;
    assign o_idex_instruction = idex_q.instruction;
    assign o_idex_pc          = idex_q.pc;
    assign o_idex_rs1_value   = idex_q.rs1_value;
    assign o_idex_rs2_value   = idex_q.rs2_value;
    assign o_idex_immediate   = idex_q.immediate;
    assign o_idex_rd          = idex_q.rd;
    assign o_idex_alu_op      = idex_q.alu_op;
    assign o_idex_alu_src     = idex_q.alu_src;
    assign o_idex_op_a_pc     = idex_q.op_a_pc;
    assign o_idex_branch      = idex_q.branch;
    assign o_idex_jump        = idex_q.jump;
    assign o_idex_mem_write   = idex_q.mem_write;
    assign o_idex_mem_read    = idex_q.mem_read;
    assign o_idex_mem_to_reg  = idex_q.mem_to_reg;
    assign o_idex_reg_write   = idex_q.reg_write;
    assign o_idex_illegal     = idex_q.illegal;
endmodule
